// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit bus writer: one CPU byte becomes two timed E strobes, then busy for the LCD execution time.
// Latency: busy rises the cycle after wr is accepted and lasts 2*T_AS + 2*T_EH + T_NIB + T_CMD/T_LONG cycles.
// Backpressure: wr is accepted only while idle; writes during busy are dropped. LCD_INIT_EN adds power-up init.
module lcd_hd44780_ctrl #(
    parameter int unsigned T_AS       = 2,
    parameter int unsigned T_EH       = 8,
    parameter int unsigned T_NIB      = 27,
    parameter int unsigned T_CMD      = 1080,
    parameter int unsigned T_LONG     = 44280,
    parameter int unsigned T_PWR      = 1080000,
    parameter int unsigned T_INIT_NIB = 110700,
    parameter int unsigned CNT_W      = 21
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic [3:0] lcd_db
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    if (longint'(T_LONG) > CNT_MAX || longint'(T_CMD) > CNT_MAX || longint'(T_PWR) > CNT_MAX ||
        longint'(T_INIT_NIB) > CNT_MAX || longint'(T_NIB) > CNT_MAX) begin : g_cnt_w_check
        $error("CNT_W too narrow for the configured timing parameters");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP_H,
        S_PULSE_H,
        S_GAP,
        S_SETUP_L,
        S_PULSE_L,
        S_WAIT
`ifdef LCD_INIT_EN
        , S_INIT_PWR,
        S_INIT_SETUP,
        S_INIT_PULSE,
        S_INIT_WAIT
`endif
    } state_t;

    function automatic logic [CNT_W-1:0] ld(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

`ifdef LCD_INIT_EN
    localparam state_t           RST_STATE = S_INIT_PWR;
    localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(T_PWR - 1);
    localparam logic             RST_BUSY  = 1'b1;
`else
    localparam state_t           RST_STATE = S_IDLE;
    localparam logic [CNT_W-1:0] RST_CNT   = '0;
    localparam logic             RST_BUSY  = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic [3:0]       db_q, db_d;
    logic             e_q, e_d;
    logic             busy_q, busy_d;
    logic             cnt_zero;
    logic             is_long;
`ifdef LCD_INIT_EN
    logic [1:0]       nib_q, nib_d;
`endif

    assign cnt_zero = (cnt_q == '0);
    // Clear display and return home take the long execution time.
    assign is_long  = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
        rs_d    = rs_q;
        data_d  = data_q;
        db_d    = db_q;
`ifdef LCD_INIT_EN
        nib_d   = nib_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (wr) begin
                    state_d = S_SETUP_H;
                    cnt_d   = ld(T_AS);
                    rs_d    = rs;
                    data_d  = data;
                    db_d    = data[7:4];
                end
            end
            S_SETUP_H: if (cnt_zero) begin state_d = S_PULSE_H; cnt_d = ld(T_EH); end
            S_PULSE_H: if (cnt_zero) begin state_d = S_GAP;     cnt_d = ld(T_NIB); end
            S_GAP: begin
                if (cnt_zero) begin
                    state_d = S_SETUP_L;
                    cnt_d   = ld(T_AS);
                    db_d    = data_q[3:0];
                end
            end
            S_SETUP_L: if (cnt_zero) begin state_d = S_PULSE_L; cnt_d = ld(T_EH); end
            S_PULSE_L: begin
                if (cnt_zero) begin
                    state_d = S_WAIT;
                    cnt_d   = is_long ? ld(T_LONG) : ld(T_CMD);
                end
            end
            S_WAIT: if (cnt_zero) state_d = S_IDLE;
`ifdef LCD_INIT_EN
            S_INIT_PWR: begin
                if (cnt_zero) begin
                    state_d = S_INIT_SETUP;
                    cnt_d   = ld(T_AS);
                    rs_d    = 1'b0;
                    db_d    = 4'h3;
                end
            end
            S_INIT_SETUP: if (cnt_zero) begin state_d = S_INIT_PULSE; cnt_d = ld(T_EH); end
            S_INIT_PULSE: if (cnt_zero) begin state_d = S_INIT_WAIT;  cnt_d = ld(T_INIT_NIB); end
            S_INIT_WAIT: begin
                if (cnt_zero) begin
                    if (nib_q == 2'd3) begin
                        state_d = S_IDLE;
                    end else begin
                        // Sequence is 0x3, 0x3, 0x3, then 0x2 to enter 4-bit mode.
                        state_d = S_INIT_SETUP;
                        cnt_d   = ld(T_AS);
                        nib_d   = nib_q + 2'd1;
                        db_d    = (nib_q == 2'd2) ? 4'h2 : 4'h3;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Strobe and busy are registered from next state so the pins never glitch.
        e_d    = (state_d == S_PULSE_H) || (state_d == S_PULSE_L);
`ifdef LCD_INIT_EN
        e_d    = e_d || (state_d == S_INIT_PULSE);
`endif
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= RST_CNT;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            db_q    <= 4'h0;
            e_q     <= 1'b0;
            busy_q  <= RST_BUSY;
`ifdef LCD_INIT_EN
            nib_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            db_q    <= db_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
`ifdef LCD_INIT_EN
            nib_q   <= nib_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign lcd_e  = e_q;
    assign lcd_rw = 1'b0;
    assign lcd_rs = rs_q;
    assign lcd_db = db_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Randomized bench for lcd_hd44780_ctrl: a transaction-level model predicts accepted bytes, nibbles,
// strobe timing and busy length; a pin monitor reconstructs the same from the LCD bus.
module tb_lcd_hd44780_ctrl;

    localparam int T_AS = 2, T_EH = 8, T_NIB = 27, T_CMD = 1080, T_LONG = 2000;
    localparam int T_PWR = 100, T_INIT_NIB = 50;
`ifdef LCD_INIT_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       wr      = 1'b0;
    logic       rs      = 1'b0;
    logic [7:0] data    = 8'h00;
    logic       busy, lcd_e, lcd_rw, lcd_rs;
    logic [3:0] lcd_db;

    lcd_hd44780_ctrl #(
        .T_AS(T_AS), .T_EH(T_EH), .T_NIB(T_NIB), .T_CMD(T_CMD), .T_LONG(T_LONG),
        .T_PWR(T_PWR), .T_INIT_NIB(T_INIT_NIB), .CNT_W(21)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .wr(wr), .rs(rs), .data(data),
        .busy(busy), .lcd_e(lcd_e), .lcd_rw(lcd_rw), .lcd_rs(lcd_rs), .lcd_db(lcd_db)
    );

    always #5 sys_clk = ~sys_clk;

    int errs = 0, checks = 0;
    int cyc = 0, free_at = 0;
    bit model_on = 1'b1;

    // Observed bus events
    logic [4:0] pulse_q[$];
    int at_q[$], width_q[$], dur_q[$], rise_q[$];
    int busy_len = 0, e_len = 0, glitches = 0, rw_bad = 0;
    logic prev_e = 1'b0, prev_rs = 1'b0;
    logic [3:0] prev_db = 4'h0;

    // Expected bus events
    logic [4:0] exp_nib_q[$];
    int exp_at_q[$], exp_w_q[$], exp_dur_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Model: one byte at a time, writes arriving while the previous byte is in flight are dropped.
    always @(posedge sys_clk) begin
        cyc++;
        if (!rst_n) begin
            free_at = 0;
        end else if (model_on && wr && cyc >= free_at) begin
            automatic bit long_cmd = !rs && (data >= 8'h01 && data <= 8'h03);
            automatic int dur = 2 * T_AS + 2 * T_EH + T_NIB + (long_cmd ? T_LONG : T_CMD);
            exp_nib_q.push_back({rs, data[7:4]});
            exp_nib_q.push_back({rs, data[3:0]});
            exp_at_q.push_back(T_AS);
            exp_at_q.push_back(T_AS + T_EH + T_NIB + T_AS);
            exp_w_q.push_back(T_EH);
            exp_w_q.push_back(T_EH);
            exp_dur_q.push_back(dur);
            free_at = cyc + dur + 1;
        end
    end

    always @(negedge sys_clk) begin
        if (lcd_e && !prev_e) begin
            pulse_q.push_back({lcd_rs, lcd_db});
            at_q.push_back(busy_len);
            e_len = 0;
        end
        if (lcd_e) e_len++;
        if (!lcd_e && prev_e) width_q.push_back(e_len);
        if (lcd_e && prev_e && (lcd_db != prev_db || lcd_rs != prev_rs)) glitches++;
        if (lcd_rw !== 1'b0) rw_bad++;
        if (!rst_n) begin
            busy_len = 0;
        end else if (busy) begin
            if (busy_len == 0) rise_q.push_back(cyc);
            busy_len++;
        end else if (busy_len != 0) begin
            dur_q.push_back(busy_len);
            busy_len = 0;
        end
        prev_e = lcd_e; prev_db = lcd_db; prev_rs = lcd_rs;
    end

    task automatic clear_all();
        pulse_q.delete(); at_q.delete(); width_q.delete(); dur_q.delete(); rise_q.delete();
        exp_nib_q.delete(); exp_at_q.delete(); exp_w_q.delete(); exp_dur_q.delete();
        glitches = 0; rw_bad = 0;
    endtask

    task automatic do_write(input logic r, input logic [7:0] d);
        @(posedge sys_clk); #1;
        wr = 1'b1; rs = r; data = d;
        @(posedge sys_clk); #1;
        wr = 1'b0; rs = 1'($urandom); data = 8'($urandom);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        @(negedge sys_clk);
        while (busy && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        chk("wait_idle", busy, 1'b0);
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":pulses"}, pulse_q.size(), exp_nib_q.size());
        chk({tag, ":bytes"}, dur_q.size(), exp_dur_q.size());
        while (pulse_q.size() > 0 && exp_nib_q.size() > 0 && width_q.size() > 0) begin
            chk({tag, ":nibble"}, pulse_q.pop_front(), exp_nib_q.pop_front());
            chk({tag, ":e_setup"}, at_q.pop_front(), exp_at_q.pop_front());
            chk({tag, ":e_width"}, width_q.pop_front(), exp_w_q.pop_front());
        end
        while (dur_q.size() > 0 && exp_dur_q.size() > 0)
            chk({tag, ":busy_len"}, dur_q.pop_front(), exp_dur_q.pop_front());
        chk({tag, ":db_change_e_high"}, glitches, 0);
        chk({tag, ":rw_high"}, rw_bad, 0);
        clear_all();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded cycle budget, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst:lcd_e", lcd_e, 1'b0);
        chk("rst:lcd_rw", lcd_rw, 1'b0);
        chk("rst:lcd_rs", lcd_rs, 1'b0);
        chk("rst:lcd_db", lcd_db, 4'h0);
        chk("rst:busy", busy, BUSY_RST);
        #1 rst_n = 1'b1;

`ifdef LCD_INIT_EN
        model_on = 1'b0;
        repeat (199) @(posedge sys_clk);
        #1 wr = 1'b1; rs = 1'b1; data = 8'h42;
        @(posedge sys_clk);
        #1 wr = 1'b0;
        wait_idle(1000);
        chk("init:busy_len", (dur_q.size() > 0) ? dur_q[0] : 0, T_PWR + 4 * (T_AS + T_EH + T_INIT_NIB));
        chk("init:pulses", pulse_q.size(), 4);
        for (int i = 0; i < 4 && i < pulse_q.size() && i < width_q.size(); i++) begin
            chk("init:nibble", pulse_q[i], (i == 3) ? 5'h02 : 5'h03);
            chk("init:e_width", width_q[i], T_EH);
        end
        clear_all();
        model_on = 1'b1;
`else
        wait_idle(1000);
`endif

        // Directed: data byte, then short and long commands.
        do_write(1'b1, 8'h48);
        wait_idle(5000);
        chk("data48:busy_len", (dur_q.size() > 0) ? dur_q[0] : 0, 1127);
        check_all("data48");
        do_write(1'b0, 8'h01); wait_idle(5000);
        do_write(1'b0, 8'h02); wait_idle(5000);
        do_write(1'b0, 8'h03); wait_idle(5000);
        do_write(1'b0, 8'h28); wait_idle(5000);
        do_write(1'b1, 8'h01); wait_idle(5000);
        check_all("cmds");

        // Random bytes with a bias toward the long commands.
        for (int i = 0; i < 12; i++) begin
            automatic logic       r = 1'($urandom);
            automatic logic [7:0] d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                r = 1'b0;
                d = 8'($urandom_range(1, 3));
            end
            repeat ($urandom_range(0, 5)) @(posedge sys_clk);
            do_write(r, d);
            wait_idle(5000);
        end
        check_all("random");

        // A second write 500 cycles into the first must vanish.
        do_write(1'b1, 8'h41);
        repeat (500) @(posedge sys_clk);
        do_write(1'b1, 8'h42);
        wait_idle(5000);
        check_all("collision");

        // wr held high: three back-to-back transfers one busy period plus one cycle apart.
        @(posedge sys_clk); #1;
        wr = 1'b1; rs = 1'b1; data = 8'h55;
        repeat (2300) @(posedge sys_clk);
        #1 wr = 1'b0;
        wait_idle(5000);
        chk("b2b:rises", rise_q.size(), 3);
        for (int i = 1; i < rise_q.size(); i++)
            chk("b2b:period", rise_q[i] - rise_q[i-1], 2 * T_AS + 2 * T_EH + T_NIB + T_CMD + 1);
        check_all("b2b");

        // Reset in the middle of the high-nibble strobe.
        do_write(1'b1, 8'hA7);
        begin
            int n = 0;
            @(negedge sys_clk);
            while (!lcd_e && n < 100) begin
                @(negedge sys_clk);
                n++;
            end
            chk("rstmid:e_seen", lcd_e, 1'b1);
        end
        @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid:lcd_e", lcd_e, 1'b0);
        chk("rstmid:busy", busy, BUSY_RST);
        chk("rstmid:lcd_rs", lcd_rs, 1'b0);
        chk("rstmid:lcd_db", lcd_db, 4'h0);
        repeat (3) @(posedge sys_clk);
        clear_all();
        #2 rst_n = 1'b1;
        wait_idle(2000);
        chk("rstmid:no_resume", pulse_q.size(), 0);
        clear_all();
        do_write(1'b1, 8'h3C);
        wait_idle(5000);
        check_all("after_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Timed HD44780 4-bit-bus LCD writer between the CPU I/O register space and the lcd_e/lcd_rw/lcd_rs/lcd_db[7:4] board pins.
- Replaces software bit-banging of io_lcd. The CPU issues one byte write with an RS flag. The block sends it as two nibbles with correct E setup, pulse and hold timing, then stays busy for the controller's execution time.
- Board top maps a write to the LCD I/O address onto wr. busy is readable back by the CPU.

Parameters:
- T_AS, 2, cycles from RS/DB valid to E rising (address setup).
- T_EH, 8, cycles E stays high (≥230 ns at 27 MHz).
- T_NIB, 27, cycles between the high-nibble E falling edge and low-nibble setup start (≈1 µs).
- T_CMD, 1080, post-byte wait for normal commands and data (≈40 µs).
- T_LONG, 44280, post-byte wait for clear/home (≈1.64 ms).
- T_PWR, 1080000, power-up wait before the init sequence (≈40 ms; used only with the optional feature).
- T_INIT_NIB, 110700, wait after each init nibble (≈4.1 ms; used only with the optional feature).
- CNT_W, 21, timer width; must hold the largest T_* value.

Ports:
- sys_clk  in  1  system clock (27 MHz on board)
- rst_n  in  1  asynchronous active-low reset
- wr  in  1  write request, sampled each rising edge
- rs  in  1  register select for this byte (0 = command, 1 = data)
- data  in  8  byte to send
- busy  out  1  high while a transfer, wait or init is in progress
- lcd_e  out  1  LCD enable strobe
- lcd_rw  out  1  LCD read/write; constant 0 (write only)
- lcd_rs  out  1  LCD register select
- lcd_db  out  4  LCD data bus D7..D4

Behaviour:
- Single clock, sys_clk. rst_n asynchronous active-low; all registers clear immediately on assertion.
- Reset values:
  - lcd_e=0, lcd_rw=0, lcd_rs=0, lcd_db=0.
  - busy=0 without LCD_INIT_EN; busy=1 with it.
- One down-counter, CNT_W bits. Each timed state loads N-1 on entry and exits the cycle the counter reads 0, so it lasts exactly N cycles.
- States:
  - IDLE: busy=0.
  - SETUP_H (T_AS): lcd_e=0.
  - PULSE_H (T_EH): lcd_e=1.
  - GAP (T_NIB): lcd_e=0.
  - SETUP_L (T_AS): lcd_e=0.
  - PULSE_L (T_EH): lcd_e=1.
  - WAIT (T_CMD or T_LONG): lcd_e=0.
  - Init states: see Optional Feature.
- Acceptance:
  - A write is accepted on the edge where wr=1 and the state is IDLE. The block latches rs and data at that edge and moves to SETUP_H; busy=1 from the next cycle.
  - wr while busy=1 is ignored and not queued.
- Bus sequencing:
  - SETUP_H, PULSE_H and GAP drive lcd_rs=rs_latched and lcd_db=data_latched[7:4].
  - SETUP_L, PULSE_L and WAIT drive lcd_db=data_latched[3:0].
  - lcd_db changes only while lcd_e=0.
- Wait selection: WAIT length is T_LONG when rs_latched=0 and data_latched is 0x01, 0x02 or 0x03; otherwise T_CMD.
- Return to IDLE:
  - busy falls on the edge leaving WAIT.
  - busy duration is 2*T_AS + 2*T_EH + T_NIB + T_wait cycles.
  - wr held high is accepted on the first IDLE cycle, giving a period of busy duration + 1.
- lcd_rs and lcd_db hold their last values in IDLE.
- Reset mid-transfer: lcd_e drops to 0 at once; any partial byte is lost; nothing resumes after reset.

Optional Feature:
- Macro: LCD_INIT_EN.
- Defined:
  - After reset the FSM runs INIT_PWR (T_PWR cycles).
  - It then sends four single nibbles with lcd_rs=0: 0x3, 0x3, 0x3, 0x2. Each uses T_AS setup, T_EH pulse and a T_INIT_NIB wait.
  - This switches the LCD to 4-bit mode. Then IDLE, busy=0.
  - Total busy = T_PWR + 4*(T_AS + T_EH + T_INIT_NIB) cycles.
  - wr during init is ignored.
- Not defined: reset goes straight to IDLE with busy=0; software performs the init.

Test Plan:
- Bench uses defaults unless stated.
- Data write: wr pulse, rs=1, data=0x48 -> exactly two lcd_e pulses of 8 cycles; lcd_db=4 then 8; lcd_rs=1; E rises 2 cycles after DB is valid; busy high for 1127 cycles; lcd_rw=0 throughout.
- Long command: rs=0, data=0x01 -> busy 44327 cycles. Same check with data=0x02 and 0x03. Also rs=0, data=0x28 -> busy 1127 cycles.
- Collision: wr with 0x41, then wr with 0x42 500 cycles later -> only two E pulses total; lcd_db shows 4,1 only; 0x42 never appears.
- Back-to-back: wr held high with data=0x55, rs=1 for 3 transfers -> E pulses in groups with a 1128-cycle period; no glitch on lcd_e.
- Reset mid-pulse: assert rst_n=0 during PULSE_H -> lcd_e=0 in the same cycle, asynchronously; all outputs at reset values; after release the next wr runs a complete, normal sequence.
- Init sequence (LCD_INIT_EN, T_PWR=100, T_INIT_NIB=50) -> four E pulses with lcd_db=3,3,3,2 and lcd_rs=0; busy falls exactly at 100+4*(2+8+50)=340 cycles after reset release; wr at cycle 200 is ignored.
